// File: rtl/pe_array_run_controller.sv
// Run controller for a PE array: sequences PE reset, enables execution, and
// reports normal completion (halted + quiescent for a hold window) or timeout.
module pe_array_run_controller #(
    parameter int NUM_PES       = 16,
    parameter int RESET_CYCLES  = 4,
    parameter int QUIESCE_HOLD  = 2,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NUM_PES-1:0]       execute_mask,
    input  logic [COUNTER_WIDTH-1:0] timeout_limit,
    input  logic [NUM_PES-1:0]       pe_halted,
    input  logic [NUM_PES-1:0]       pe_channels_quiescent,
    output logic                     pe_reset,
    output logic                     pe_enable,
    output logic [NUM_PES-1:0]       pe_execute,
    output logic                     busy,
    output logic                     done,
    output logic                     timed_out,
    output logic                     start_error,
    output logic [COUNTER_WIDTH-1:0] cycle_count
);
    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam int QH_W = $clog2(QUIESCE_HOLD + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t                   state_q, state_d;
    logic [RC_W-1:0]          rst_cnt_q, rst_cnt_d;
    logic [QH_W-1:0]          hold_q, hold_d, hold_n;
    logic [NUM_PES-1:0]       mask_q, mask_d;
    logic [COUNTER_WIDTH-1:0] limit_q, limit_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d, count_inc;
    logic                     done_q, done_d;
    logic                     timed_out_q, timed_out_d;
    logic                     start_error_q, start_error_d;
    logic                     pe_reset_q, pe_enable_q, busy_q;
    logic [NUM_PES-1:0]       pe_execute_q;
    logic                     term, hit_limit, run_d, busy_d;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
        return (&v) ? v : v + COUNTER_WIDTH'(1);
    endfunction

    // Unmasked PEs may stay un-halted, but every PE's channels must be quiet.
    always_comb begin
        term      = (&(pe_halted | ~mask_q)) & (&pe_channels_quiescent);
        count_inc = sat_inc(count_q);
        hit_limit = (limit_q != '0) && (count_inc == limit_q);
    end

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        hold_d        = hold_q;
        hold_n        = '0;
        mask_d        = mask_q;
        limit_d       = limit_q;
        count_d       = count_q;
        done_d        = done_q;
        timed_out_d   = timed_out_q;
        start_error_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start && !abort) begin
                    if (|execute_mask) begin
                        state_d     = ST_RESET;
                        mask_d      = execute_mask;
                        limit_d     = timeout_limit;
                        count_d     = '0;
                        done_d      = 1'b0;
                        timed_out_d = 1'b0;
                        rst_cnt_d   = '0;
                        hold_d      = '0;
                    end else begin
                        start_error_d = 1'b1;
                    end
                end
            end
            ST_RESET: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            ST_RUN, ST_DRAIN: begin
                // The aborted cycle itself still counts as a run cycle.
                count_d = count_inc;
                if (abort) begin
                    state_d     = ST_IDLE;
                    hold_d      = '0;
                    done_d      = 1'b0;
                    timed_out_d = 1'b0;
                end else if (term) begin
                    hold_n = (state_q == ST_RUN) ? QH_W'(1) : hold_q + QH_W'(1);
                    if (hold_n >= QH_W'(QUIESCE_HOLD)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = '0;
                    end else if (hit_limit) begin
                        state_d     = ST_TIMEOUT;
                        timed_out_d = 1'b1;
                        hold_d      = '0;
                    end else begin
                        state_d = ST_DRAIN;
                        hold_d  = hold_n;
                    end
                end else begin
                    hold_d = '0;
                    if (hit_limit) begin
                        state_d     = ST_TIMEOUT;
                        timed_out_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        run_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        busy_d = run_d || (state_d == ST_RESET);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rst_cnt_q     <= '0;
            hold_q        <= '0;
            count_q       <= '0;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            start_error_q <= 1'b0;
            pe_reset_q    <= 1'b1;
            pe_enable_q   <= 1'b0;
            pe_execute_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            hold_q        <= hold_d;
            count_q       <= count_d;
            done_q        <= done_d;
            timed_out_q   <= timed_out_d;
            start_error_q <= start_error_d;
            pe_reset_q    <= (state_d == ST_RESET);
            pe_enable_q   <= run_d;
            pe_execute_q  <= run_d ? mask_d : '0;
            busy_q        <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        mask_q  <= mask_d;
        limit_q <= limit_d;
    end

    assign pe_reset    = pe_reset_q;
    assign pe_enable   = pe_enable_q;
    assign pe_execute  = pe_execute_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign start_error = start_error_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_pe_array_run_controller.sv
// Directed bench for pe_array_run_controller: cycle table plus multi-cycle scenarios.
module tb_pe_array_run_controller;
    logic        clock = 1'b0;
    logic        reset, start, abort;
    logic [15:0] execute_mask, pe_halted, pe_channels_quiescent;
    logic [31:0] timeout_limit;
    logic        pe_reset, pe_enable, busy, done, timed_out, start_error;
    logic [15:0] pe_execute;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        start;
        logic        abort;
        logic [15:0] mask;
        logic [31:0] limit;
        logic [15:0] halted;
        logic [15:0] quiesc;
        logic        e_rst;
        logic        e_en;
        logic [15:0] e_exec;
        logic        e_busy;
        logic        e_done;
        logic        e_to;
        logic        e_serr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[13];

    always #5 clock = ~clock;

    pe_array_run_controller #(
        .NUM_PES(16), .RESET_CYCLES(4), .QUIESCE_HOLD(2), .COUNTER_WIDTH(32)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .execute_mask(execute_mask), .timeout_limit(timeout_limit),
        .pe_halted(pe_halted), .pe_channels_quiescent(pe_channels_quiescent),
        .pe_reset(pe_reset), .pe_enable(pe_enable), .pe_execute(pe_execute),
        .busy(busy), .done(done), .timed_out(timed_out),
        .start_error(start_error), .cycle_count(cycle_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cmp(input string tag, input string sig, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", tag, sig, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_rst, input logic e_en,
                              input logic [15:0] e_exec, input logic e_busy, input logic e_done,
                              input logic e_to, input logic e_serr, input logic [31:0] e_cnt);
        cmp(tag, "pe_reset",    {31'd0, pe_reset},    {31'd0, e_rst});
        cmp(tag, "pe_enable",   {31'd0, pe_enable},   {31'd0, e_en});
        cmp(tag, "pe_execute",  {16'd0, pe_execute},  {16'd0, e_exec});
        cmp(tag, "busy",        {31'd0, busy},        {31'd0, e_busy});
        cmp(tag, "done",        {31'd0, done},        {31'd0, e_done});
        cmp(tag, "timed_out",   {31'd0, timed_out},   {31'd0, e_to});
        cmp(tag, "start_error", {31'd0, start_error}, {31'd0, e_serr});
        cmp(tag, "cycle_count", cycle_count,          e_cnt);
    endtask

    // Issues an accepted start, then walks through the reset window so the
    // caller resumes at the first RUN cycle. Inputs are cleared to prove latching.
    task automatic start_run(input string tag, input logic [15:0] m, input logic [31:0] l);
        execute_mask  = m;
        timeout_limit = l;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        execute_mask  = 16'h0000;
        timeout_limit = 32'd0;
        check_outs(tag, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (4) tick();
    endtask

    initial begin
        int n;
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 32'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 32'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 32'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0005, 32'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[4]  = '{1'b1, 1'b0, 16'hFFFF, 32'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[5]  = '{1'b0, 1'b0, 16'h00F0, 32'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[6]  = '{1'b0, 1'b0, 16'h00F0, 32'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[7]  = '{1'b0, 1'b0, 16'h00F0, 32'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[8]  = '{1'b0, 1'b0, 16'h00F0, 32'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1};
        tbl[9]  = '{1'b0, 1'b0, 16'h00F0, 32'd0, 16'h0005, 16'hFFFF, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
        tbl[10] = '{1'b0, 1'b0, 16'h00F0, 32'd0, 16'h0005, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3};
        tbl[11] = '{1'b0, 1'b0, 16'h00F0, 32'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 32'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'd3};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        execute_mask = 16'h0; timeout_limit = 32'd0;
        pe_halted = 16'h0; pe_channels_quiescent = 16'h0;
        repeat (2) tick();
        check_outs("reset", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            start                 = tbl[i].start;
            abort                 = tbl[i].abort;
            execute_mask          = tbl[i].mask;
            timeout_limit         = tbl[i].limit;
            pe_halted             = tbl[i].halted;
            pe_channels_quiescent = tbl[i].quiesc;
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].e_rst, tbl[i].e_en, tbl[i].e_exec,
                       tbl[i].e_busy, tbl[i].e_done, tbl[i].e_to, tbl[i].e_serr, tbl[i].e_cnt);
        end
        start = 1'b0;

        // Normal completion: PE0 halts at 10, PE1 and quiescence at 12.
        start_run("a", 16'h0003, 32'd0);
        for (int c = 1; c <= 13; c++) begin
            pe_halted = 16'h0000;
            if (c >= 10) pe_halted[0] = 1'b1;
            if (c >= 12) pe_halted[1] = 1'b1;
            pe_channels_quiescent = (c >= 12) ? 16'hFFFF : 16'h0000;
            tick();
            if (c == 12)
                check_outs("a_drain", 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 32'd12);
        end
        check_outs("a_done", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd13);

        // Timeout after 20 run cycles.
        pe_halted = 16'h0000;
        pe_channels_quiescent = 16'hFFFF;
        start_run("b", 16'h0001, 32'd20);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 19)
                check_outs("b_run19", 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'd19);
        end
        check_outs("b_timeout", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd20);
        tick();
        check_outs("b_hold", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd20);

        // PE3 quiescence drops during DRAIN: hold restarts.
        pe_halted = 16'hFFFF;
        start_run("c", 16'hFFFF, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            pe_channels_quiescent = (c == 2) ? 16'hFFF7 : 16'hFFFF;
            tick();
            if (c == 3)
                check_outs("c_redrain", 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
        end
        check_outs("c_done", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4);

        // Abort in RUN cycle 5 with a simultaneous start.
        pe_halted = 16'h0000;
        start_run("d", 16'h0001, 32'd0);
        repeat (4) tick();
        abort = 1'b1; start = 1'b1; execute_mask = 16'hFFFF;
        tick();
        abort = 1'b0; start = 1'b0; execute_mask = 16'h0000;
        check_outs("d_abort", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5);
        tick();
        check_outs("d_idle", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5);

        // Reset while in DRAIN, then a fresh run.
        pe_halted = 16'h0001;
        start_run("e", 16'h0001, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check_outs("e_reset", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        tick();
        check_outs("e_release", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        pe_halted = 16'h0000;
        execute_mask = 16'h0002; start = 1'b1;
        tick();
        start = 1'b0; execute_mask = 16'h0000;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (pe_reset) begin
                n++;
                tick();
            end
        end
        cmp("e", "reset_len", n, 32'd4);
        check_outs("e_run", 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
